// File: rtl/sar_scan_scheduler_pkg.sv
// Shared definitions for the SAR scan scheduler.
//  SarBits : width of the SAR core conversion code
//  state_e : scheduler FSM states
package sar_scan_scheduler_pkg;

  localparam int unsigned SarBits = 8;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSettle  = 3'd1,
    StConvert = 3'd2,
    StCapture = 3'd3,
    StOutput  = 3'd4
  } state_e;

endpackage

// File: rtl/sar_scan_scheduler_chan_picker.sv
// Combinational channel picker: finds the lowest set bit of mask strictly above index.
// With from_bottom=1 the index is ignored and the lowest set bit of the whole mask is returned.
// Ports:
//  mask        in   NCH          candidate channels
//  from_bottom in   1            search from below channel 0
//  index       in   clog2(NCH)   search starts above this channel
//  pick        out  clog2(NCH)   selected channel (0 when wrap=1)
//  wrap        out  1            no candidate found, search would wrap around
module sar_scan_scheduler_chan_picker #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         mask,
  input  logic                   from_bottom,
  input  logic [$clog2(NCH)-1:0] index,
  output logic [$clog2(NCH)-1:0] pick,
  output logic                   wrap
);

  localparam int unsigned CW = $clog2(NCH);

  // Scan downwards so the lowest qualifying bit is the last one written.
  always_comb begin
    pick = '0;
    wrap = 1'b1;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (from_bottom || (i > int'(index)))) begin
        pick = CW'(i);
        wrap = 1'b0;
      end
    end
  end

endmodule

// File: rtl/sar_scan_scheduler.sv
// SAR scan scheduler: steps the analog mux over the enabled channels, holds the SAR core in
// reset while the mux settles, runs 2^AVG_LOG2 fixed-length conversions per channel and
// hands out one averaged code per channel over a valid/ready handshake.
// Ports:
//  clk          in   system clock
//  reset_in     in   synchronous active-high reset
//  start        in   pulse, begins one scan of chan_mask (ignored while busy or mask==0)
//  continuous   in   rescan automatically after each scan
//  chan_mask    in   enabled channels, sampled at scan start / relatch
//  core_code    in   SAR core output code
//  core_rst_n   out  SAR core reset, low holds the core in reset
//  mux_sel      out  analog mux select
//  busy         out  scan in progress
//  result_data  out  averaged code
//  result_chan  out  channel of result_data
//  result_valid out  result available, held until result_ready
//  result_ready in   consumer accepts result
module sar_scan_scheduler
  import sar_scan_scheduler_pkg::*;
#(
  parameter int unsigned NCH           = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CONV_CYCLES   = 9,
  parameter int unsigned AVG_LOG2      = 2
) (
  input  logic                   clk,
  input  logic                   reset_in,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [NCH-1:0]         chan_mask,
  input  logic [SarBits-1:0]     core_code,
  output logic                   core_rst_n,
  output logic [$clog2(NCH)-1:0] mux_sel,
  output logic                   busy,
  output logic [SarBits-1:0]     result_data,
  output logic [$clog2(NCH)-1:0] result_chan,
  output logic                   result_valid,
  input  logic                   result_ready
);

  localparam int unsigned CW     = $clog2(NCH);
  localparam int unsigned AccW   = SarBits + AVG_LOG2;
  localparam int unsigned NSamp  = 1 << AVG_LOG2;
  localparam int unsigned CntMax = (SETTLE_CYCLES > CONV_CYCLES) ? SETTLE_CYCLES : CONV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned SmpW   = AVG_LOG2 + 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [SmpW-1:0]   smp_q;
  logic [AccW-1:0]   acc_q;
  logic [CW-1:0]     mux_sel_q;
  logic [NCH-1:0]    scan_mask_q;

  logic [CW-1:0]     first_idx, next_idx;
  logic              first_wrap, next_wrap;
  logic              launch, accept, relatch;

  // Lowest enabled channel of the live mask, used at scan start and on continuous relatch.
  sar_scan_scheduler_chan_picker #(.NCH(NCH)) u_first_pick (
    .mask        (chan_mask),
    .from_bottom (1'b1),
    .index       ('0),
    .pick        (first_idx),
    .wrap        (first_wrap)
  );

  // Next channel of the latched scan mask above the one just reported.
  sar_scan_scheduler_chan_picker #(.NCH(NCH)) u_next_pick (
    .mask        (scan_mask_q),
    .from_bottom (1'b0),
    .index       (mux_sel_q),
    .pick        (next_idx),
    .wrap        (next_wrap)
  );

  assign launch  = (state_q == StIdle) && start && !first_wrap;
  assign accept  = (state_q == StOutput) && result_ready;
  assign relatch = accept && next_wrap && continuous && !first_wrap;

  // State register
  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (launch) state_d = StSettle;
      StSettle:  if (cnt_q == CntW'(SETTLE_CYCLES - 1)) state_d = StConvert;
      StConvert: if (cnt_q == CntW'(CONV_CYCLES - 1)) state_d = StCapture;
      StCapture: state_d = (smp_q == SmpW'(NSamp - 1)) ? StOutput : StConvert;
      StOutput: begin
        if (result_ready) state_d = (!next_wrap || relatch) ? StSettle : StIdle;
      end
      default:   state_d = StIdle;
    endcase
  end

  // Datapath: phase counter, sample counter, accumulator, channel tracking
  always_ff @(posedge clk) begin
    if (reset_in) begin
      cnt_q       <= '0;
      smp_q       <= '0;
      acc_q       <= '0;
      mux_sel_q   <= '0;
      scan_mask_q <= '0;
    end else begin
      // Phase counter restarts on every state change, so each phase is timed from zero.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q inside {StSettle, StConvert}) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      if (state_q == StSettle) begin
        smp_q <= '0;
        acc_q <= '0;
      end else if (state_q == StCapture) begin
        smp_q <= smp_q + SmpW'(1);
        acc_q <= acc_q + AccW'(core_code);
      end

      if (launch || relatch) begin
        scan_mask_q <= chan_mask;
        mux_sel_q   <= first_idx;
      end else if (accept && !next_wrap) begin
        mux_sel_q   <= next_idx;
      end
    end
  end

  // Outputs
  always_comb begin
    core_rst_n   = (state_q == StConvert);
    busy         = (state_q != StIdle);
    result_valid = (state_q == StOutput);
    result_data  = acc_q[AccW-1:AVG_LOG2];
    result_chan  = mux_sel_q;
    mux_sel      = mux_sel_q;
  end

endmodule

// File: tb/tb_sar_scan_scheduler.sv
// Self-checking bench for sar_scan_scheduler at default parameters.
// The SAR core is modelled per channel: conversion k on channel ch yields
// (base[ch] + step[ch]*k) mod 256, presented when the core leaves reset.
module tb_sar_scan_scheduler;

  localparam int NCH   = 4;
  localparam int NSAMP = 4;
  localparam int LAT   = 1 + 4 + NSAMP * (9 + 1);

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] chan_mask = '0;
  logic [7:0] core_code = '0;
  logic       core_rst_n;
  logic [1:0] mux_sel;
  logic       busy;
  logic [7:0] result_data;
  logic [1:0] result_chan;
  logic       result_valid;
  logic       result_ready = 1'b0;

  int n_total = 0;
  int n_bad   = 0;

  int base [NCH] = '{default: 0};
  int step [NCH] = '{default: 0};
  int conv_n [NCH] = '{default: 0};   // conversions started per channel (core model)
  int model_k [NCH] = '{default: 0};  // samples consumed per channel (reference model)
  logic rst_n_prev = 1'b0;

  sar_scan_scheduler dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .start        (start),
    .continuous   (continuous),
    .chan_mask    (chan_mask),
    .core_code    (core_code),
    .core_rst_n   (core_rst_n),
    .mux_sel      (mux_sel),
    .busy         (busy),
    .result_data  (result_data),
    .result_chan  (result_chan),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] code_of(input int ch, input int k);
    int v;
    v = base[ch] + step[ch] * k;
    return v[7:0];
  endfunction

  // Core model: a new code appears each time the core is released from reset.
  always @(negedge clk) begin
    rst_n_prev <= core_rst_n;
    if (core_rst_n && !rst_n_prev) begin
      core_code       <= code_of(int'(mux_sel), conv_n[mux_sel]);
      conv_n[mux_sel] <= conv_n[mux_sel] + 1;
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a scan; lat counts rising edges from the one sampling start until valid is seen.
  // At edge disturb_at a second start pulse and a different mask are applied.
  task automatic launch(input logic [3:0] mask, input int disturb_at, output int lat);
    chan_mask = mask;
    start     = 1'b1;
    lat       = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = (disturb_at != 0) && (lat == disturb_at);
      if (lat == disturb_at) chan_mask = ~mask;
      if (result_valid) break;
    end
    start = 1'b0;
  endtask

  // Wait for a result, check it, hold ready low for hold cycles checking stability, accept.
  task automatic take(input int exp_ch, input int exp_dat, input int hold);
    int n;
    n = 0;
    while (!result_valid && n < 200) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      check_eq("valid_timeout", 0, 1);
      return;
    end
    check_eq("res_chan", int'(result_chan), exp_ch);
    check_eq("res_data", int'(result_data), exp_dat);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("stall_valid", int'(result_valid), 1);
      check_eq("stall_chan", int'(result_chan), exp_ch);
      check_eq("stall_data", int'(result_data), exp_dat);
      check_eq("stall_mux", int'(mux_sel), exp_ch);
      check_eq("stall_core_rst", int'(core_rst_n), 0);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic expect_result(input int ch, input int hold);
    int sum;
    sum = 0;
    for (int j = 0; j < NSAMP; j++) sum += int'(code_of(ch, model_k[ch] + j));
    model_k[ch] += NSAMP;
    take(ch, sum / NSAMP, hold);
  endtask

  initial begin
    int lat;
    logic [3:0] m;

    // Reset state
    reset_in = 1'b1;
    repeat (3) tick();
    check_eq("rst_core_rst", int'(core_rst_n), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(result_valid), 0);
    check_eq("rst_data", int'(result_data), 0);
    check_eq("rst_chan", int'(result_chan), 0);
    check_eq("rst_mux", int'(mux_sel), 0);
    reset_in = 1'b0;
    tick();

    // Averaging truncates: 0x10..0x13 -> 0x46>>2 = 0x11
    base[1] = 'h10; step[1] = 1;
    launch(4'b0010, 0, lat);
    check_eq("ramp_lat", lat, LAT);
    take(1, 'h11, 0);
    model_k[1] += NSAMP;
    check_eq("ramp_idle", int'(busy), 0);

    // Two-channel scan with constant codes
    base[0] = 'h40; step[0] = 0;
    base[2] = 'h80; step[2] = 0;
    launch(4'b0101, 0, lat);
    check_eq("basic_lat", lat, LAT);
    take(0, 'h40, 0);
    take(2, 'h80, 0);
    model_k[0] += NSAMP;
    model_k[2] += NSAMP;
    check_eq("basic_idle", int'(busy), 0);

    // Backpressure: ready held low for 10 cycles
    base[3] = int'($urandom_range(0, 255)); step[3] = int'($urandom_range(0, 9));
    launch(4'b1001, 0, lat);
    expect_result(0, 10);
    expect_result(3, 0);
    check_eq("bp_idle", int'(busy), 0);

    // Start pulse and mask change mid-scan are ignored
    launch(4'b0110, 20, lat);
    check_eq("dist_lat", lat, LAT);
    expect_result(1, 0);
    expect_result(2, 0);
    check_eq("dist_idle", int'(busy), 0);

    // Continuous rescan, then relatch of an empty mask stops
    continuous = 1'b1;
    launch(4'b1001, 0, lat);
    expect_result(0, 0);
    expect_result(3, 0);
    expect_result(0, 1);
    chan_mask = 4'b0000;
    expect_result(3, 0);
    check_eq("cont_idle", int'(busy), 0);

    // Continuous dropped mid-scan finishes the current scan
    launch(4'b0011, 0, lat);
    expect_result(0, 0);
    continuous = 1'b0;
    expect_result(1, 0);
    check_eq("drop_idle", int'(busy), 0);

    // Start with empty mask is ignored
    chan_mask = 4'b0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("zero_mask_busy", int'(busy), 0);
    tick();
    check_eq("zero_mask_busy2", int'(busy), 0);

    // Randomized single scans
    for (int it = 0; it < 6; it++) begin
      m = 4'($urandom_range(1, 15));
      for (int c = 0; c < NCH; c++) begin
        base[c] = int'($urandom_range(0, 255));
        step[c] = int'($urandom_range(0, 40));
      end
      launch(m, 0, lat);
      check_eq("rnd_lat", lat, LAT);
      for (int c = 0; c < NCH; c++) begin
        if (m[c]) expect_result(c, int'($urandom_range(0, 3)));
      end
      check_eq("rnd_idle", int'(busy), 0);
    end

    // Reset in the middle of a conversion
    chan_mask = 4'b0100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check_eq("mid_core_run", int'(core_rst_n), 1);
    check_eq("mid_mux", int'(mux_sel), 2);
    reset_in = 1'b1;
    tick();
    check_eq("mid_rst_core", int'(core_rst_n), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_valid", int'(result_valid), 0);
    check_eq("mid_rst_mux", int'(mux_sel), 0);
    reset_in = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
